// File: rtl/music_sequencer.sv
// Song ROM sequencer: fetches {dur, note} entries and times each note in TICK_DIV-cycle units.
// Optional pause input is enabled by defining MUSIC_SEQ_PAUSE_EN.
module music_sequencer #(
  parameter int TICK_DIV  = 750000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
`ifdef MUSIC_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [4:0]        choose,
  output logic              busy,
  output logic              done
);

  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_MAX = (GAP_TICKS > 7) ? GAP_TICKS : 7;
  localparam int UNIT_W  = $clog2(GAP_MAX + 1);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [UNIT_W-1:0] GAP_LAST  = UNIT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    s_idle,
    s_fetch,
    s_load,
    s_play,
    s_gap,
    s_done
  } state_t;

  state_t state, state_nx;

  logic [PRE_W-1:0]  pre_cnt;
  logic [UNIT_W-1:0] unit_cnt;
  logic [4:0]        note_r;
  logic [2:0]        dur_r;

  logic [2:0]        dec_dur;
  logic [4:0]        dec_note;
  logic              freeze;
  logic              tick;
  logic              play_last;
  logic              gap_last;
  logic              at_end;

  logic [ADDR_W-1:0] rom_addr_nx;
  logic [4:0]        choose_nx;
  logic              busy_nx;
  logic              done_nx;
  logic              cnt_clr;
  logic              cnt_run;
  logic              note_ld;

  assign dec_dur  = rom_data[7:5];
  assign dec_note = rom_data[4:0];

`ifdef MUSIC_SEQ_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  assign tick      = (pre_cnt == PRE_LAST);
  assign play_last = tick && (unit_cnt == UNIT_W'(dur_r - 3'd1));
  assign gap_last  = tick && (unit_cnt == GAP_LAST);
  // The last ROM slot behaves like an end marker so playback never wraps into stale data.
  assign at_end    = (rom_addr == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= s_idle;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      s_idle: begin
        if (start) state_nx = s_fetch;
      end
      s_fetch: state_nx = s_load;
      s_load: begin
        if (dec_dur == 3'd0) state_nx = loop_en ? s_fetch : s_done;
        else                 state_nx = s_play;
      end
      s_play: begin
        if (!freeze && play_last) begin
          if (GAP_TICKS > 0)            state_nx = s_gap;
          else if (at_end && !loop_en)  state_nx = s_done;
          else                          state_nx = s_fetch;
        end
      end
      s_gap: begin
        if (!freeze && gap_last) state_nx = (at_end && !loop_en) ? s_done : s_fetch;
      end
      s_done: state_nx = s_idle;
      default: state_nx = s_idle;
    endcase
    // stop beats everything, including a simultaneous start.
    if (stop) state_nx = s_idle;
  end

  always_comb begin
    rom_addr_nx = rom_addr;
    choose_nx   = choose;
    cnt_clr     = 1'b0;
    cnt_run     = 1'b0;
    note_ld     = 1'b0;
    unique case (state)
      s_idle: begin
        choose_nx = 5'd0;
        if (start) rom_addr_nx = '0;
      end
      s_load: begin
        if (dec_dur == 3'd0) begin
          if (loop_en) rom_addr_nx = '0;
          else         choose_nx   = 5'd0;
        end else begin
          choose_nx = dec_note;
          note_ld   = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      s_play: begin
        cnt_run   = !freeze;
        choose_nx = freeze ? 5'd0 : note_r;
        if (state_nx == s_gap) begin
          choose_nx = 5'd0;
          cnt_clr   = 1'b1;
        end else if (state_nx == s_fetch) begin
          rom_addr_nx = at_end ? '0 : rom_addr + 1'b1;
        end else if (state_nx == s_done) begin
          choose_nx = 5'd0;
        end
      end
      s_gap: begin
        cnt_run   = !freeze;
        choose_nx = 5'd0;
        if (state_nx == s_fetch) rom_addr_nx = at_end ? '0 : rom_addr + 1'b1;
      end
      s_done: choose_nx = 5'd0;
      default: ;
    endcase
    if (stop && state != s_idle) begin
      rom_addr_nx = '0;
      choose_nx   = 5'd0;
      cnt_run     = 1'b0;
    end
    busy_nx = (state_nx != s_idle);
    done_nx = (state_nx == s_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      choose   <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pre_cnt  <= '0;
      unit_cnt <= '0;
    end else begin
      rom_addr <= rom_addr_nx;
      choose   <= choose_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      // Counters restart on entry to PLAY and GAP so every note length is exact.
      if (cnt_clr) begin
        pre_cnt  <= '0;
        unit_cnt <= '0;
      end else if (cnt_run) begin
        if (tick) begin
          pre_cnt  <= '0;
          unit_cnt <= unit_cnt + 1'b1;
        end else begin
          pre_cnt  <= pre_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (note_ld) begin
      dur_r  <= dec_dur;
      note_r <= dec_note;
    end
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Plays a song stored in a synchronous ROM by stepping through note entries and timing each one.
- Drives the 5-bit note index `choose` into the downstream note-to-period lookup, which feeds the PWM beeper.
- Handles start/stop, end-of-song detection, optional looping, and a silent articulation gap between notes.

Parameters:
- TICK_DIV, 750000, clk cycles per duration unit (62.5 ms at 12 MHz); minimum 2.
- GAP_TICKS, 1, silent units inserted after every note; 0 disables the gap.
- ADDR_W, 8, ROM address width; song length is at most 2^ADDR_W entries.

Ports:
- clk  input  1  system clock, 12 MHz
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle pulse; begins playback from address 0 when idle
- stop  input  1  single-cycle pulse; aborts playback
- loop_en  input  1  restart from address 0 on end marker instead of finishing
- rom_addr  output  ADDR_W  song ROM address
- rom_data  input  8  ROM word {dur[2:0], note[4:0]}, valid 1 cycle after rom_addr
- choose  output  5  note index to the tone lookup; 0 = silence
- busy  output  1  high in every state except IDLE
- done  output  1  single-cycle pulse when the song ends without looping

Behaviour:
- Interface: one clock domain, `clk`. Reset `rst` is synchronous and active-high.
- Reset: state=IDLE, rom_addr=0, choose=0, busy=0, done=0, all counters 0.
- All outputs are registered.

State machine (IDLE, FETCH, LOAD, PLAY, GAP, DONE):
- IDLE: on start, set rom_addr=0 and go to FETCH.
- FETCH: one cycle covering the ROM read latency; go to LOAD.
- LOAD: decode rom_data.
  - If dur==0 (end marker): with loop_en=1, set rom_addr=0 and go to FETCH; otherwise go to DONE.
  - Otherwise register choose=note and dur, clear counters, go to PLAY.
- PLAY: hold choose for exactly dur*TICK_DIV cycles.
  - Then, if GAP_TICKS>0, set choose=0 and go to GAP.
  - Otherwise go straight to the advance step.
- GAP: hold choose=0 for GAP_TICKS*TICK_DIV cycles, then advance.
- Advance: rom_addr+1, go to FETCH.
  - If rom_addr is at 2^ADDR_W-1, treat it as an end marker: apply the loop_en rule, with no wrap into a stale entry.
- DONE: done=1 and choose=0 for one cycle, then IDLE.

Timing and counters:
- Timing uses a prescaler 0..TICK_DIV-1 and a unit counter 0..dur-1.
- The prescaler restarts on entry to PLAY and to GAP, so note lengths are exact and not phase-dependent.
- note==0 with dur>0 is a rest: silence for dur units, timed like a note.
- Note-to-note latency: the last PLAY/GAP cycle, then FETCH and LOAD give 2 dead cycles with choose=0 (or the previous note held when GAP_TICKS=0). The new choose appears on the cycle after LOAD.

Control corner cases:
- start while busy: ignored.
- stop in any non-IDLE state: next cycle goes to IDLE with choose=0 and rom_addr=0; no done pulse.
- start and stop in the same cycle: stop wins, state stays IDLE.
- loop_en is sampled only at end-of-song decisions; changing it mid-note has no effect until then.
- rst asserted mid-note: immediate return to the reset values on the next edge.

Optional Feature:
- Macro: MUSIC_SEQ_PAUSE_EN.
- Defined: adds input `pause` (1 bit).
  - While pause=1 in PLAY or GAP, the prescaler and unit counter freeze and choose is forced to 0.
  - On release, the note resumes with its remaining duration and the stored note value.
  - pause in IDLE, FETCH, LOAD or DONE has no effect.
  - stop overrides pause.
- Undefined: no `pause` port; the counters run freely.

Test Plan:
- Basic note (TICK_DIV=4, GAP_TICKS=1; ROM[0]={2,8}, ROM[1]={0,0}): pulse start → choose=8 for exactly 8 cycles, then 0 for 4 cycles. After the end marker, done pulses once; busy falls with done.
- Sequence timing (ROM {1,3},{3,15},{0,0}): measure every choose transition → 3 for 4 cycles; 0 for 4+2 cycles; 15 for 12 cycles; 0; then done. rom_addr follows 0,1,2.
- Loop (loop_en=1, same ROM): → after the end marker, rom_addr returns to 0 and choose=3 reappears with no done pulse. Deassert loop_en → done on the next pass.
- Stop mid-note during the first PLAY unit: → next cycle state=IDLE, choose=0, busy=0, rom_addr=0, done=0. A start during playback is ignored (checked at mid-note).
- Edge conditions:
  - start and stop in the same cycle → stays idle.
  - rst asserted mid-PLAY → all outputs at reset values.
  - Rest entry {2,0} → choose=0 for 8 cycles.
  - ADDR_W=2 with no end marker → stops after the ROM[3] note.
- MUSIC_SEQ_PAUSE_EN: pause 10 cycles after 3 cycles of an 8-cycle note → choose=0 during the pause, then 5 more cycles of the note; total sounding time 8 cycles.
